// File: rtl/core_apb_arbiter_if.sv
// APB bus bundle shared by the upstream ports and the downstream port of core_apb_arbiter.
interface core_apb_arbiter_if;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pwstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pwdata, pwstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata, pwstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/core_apb_arbiter.sv
// Two-master APB arbiter: m0 (core) and m1 (debug/DMA) share one downstream APB bus,
// with round-robin or fixed-priority grant and a watchdog on hung slaves.
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch request fields
// SETUP  | downstream psel=1, penable=0 for one cycle
// ACCESS | downstream psel=1, penable=1 until pready or timeout
// RESP   | one-cycle pready pulse to the granted master
module core_apb_arbiter #(
   parameter bit          FIXED_PRIO     = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   core_apb_arbiter_if.slave  m0,
   core_apb_arbiter_if.slave  m1,
   core_apb_arbiter_if.master ds
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]       state_q;
   logic             last_grant_q;
   logic [31:0]      paddr_q;
   logic             pwrite_q;
   logic [31:0]      pwdata_q;
   logic [3:0]       pwstrb_q;
   logic [31:0]      rdata_q;
   logic             slverr_q;
   logic [CNT_W-1:0] cnt_q;

   logic [1:0] req;
   logic       winner;
   logic       timeout_hit;
   logic       resp_m0;
   logic       resp_m1;
   logic       unused_penable;

   assign req            = {m1.psel, m0.psel};
   assign unused_penable = m0.penable ^ m1.penable;

   always_comb begin
      winner = req[1];
      if (req == 2'b11) begin
         winner = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      end
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         pwstrb_q     <= '0;
         rdata_q      <= '0;
         slverr_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req != 2'b00) begin
                  state_q      <= S_SETUP;
                  last_grant_q <= winner;
                  paddr_q      <= winner ? m1.paddr  : m0.paddr;
                  pwrite_q     <= winner ? m1.pwrite : m0.pwrite;
                  pwdata_q     <= winner ? m1.pwdata : m0.pwdata;
                  pwstrb_q     <= winner ? m1.pwstrb : m0.pwstrb;
               end
            end
            S_SETUP: begin
               state_q <= S_ACCESS;
            end
            S_ACCESS: begin
               if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               // a real pready wins over a watchdog expiry in the same cycle
               if (ds.pready) begin
                  rdata_q  <= ds.prdata;
                  slverr_q <= ds.pslverr;
                  state_q  <= S_RESP;
               end else if (timeout_hit) begin
                  rdata_q  <= '0;
                  slverr_q <= 1'b1;
                  state_q  <= S_RESP;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ds.psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign ds.penable = (state_q == S_ACCESS);
   assign ds.paddr   = paddr_q;
   assign ds.pwrite  = pwrite_q;
   assign ds.pwdata  = pwdata_q;
   assign ds.pwstrb  = pwstrb_q;

   assign resp_m0 = (state_q == S_RESP) && !last_grant_q;
   assign resp_m1 = (state_q == S_RESP) &&  last_grant_q;

   assign m0.pready  = resp_m0;
   assign m0.prdata  = resp_m0 ? rdata_q : '0;
   assign m0.pslverr = resp_m0 & slverr_q;
   assign m1.pready  = resp_m1;
   assign m1.prdata  = resp_m1 ? rdata_q : '0;
   assign m1.pslverr = resp_m1 & slverr_q;

endmodule

// File: tb/tb_core_apb_arbiter.sv
// Bench for core_apb_arbiter: a round-robin and a fixed-priority instance run the same
// randomized master/slave traffic against a transfer-schedule reference model.
module tb_core_apb_arbiter;

   localparam int TMO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [1:0] req_en     = 2'b00;
   int         p_req      = 0;
   int         force_wait = -1;
   int         field_mode = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic string tg(input int i, input string s);
      return $sformatf("i%0d %s", i, s);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : inst
      core_apb_arbiter_if m0_bus ();
      core_apb_arbiter_if m1_bus ();
      core_apb_arbiter_if ds_bus ();

      core_apb_arbiter #(
         .FIXED_PRIO     (1'(g)),
         .TIMEOUT_CYCLES (TMO)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .m0    (m0_bus),
         .m1    (m1_bus),
         .ds    (ds_bus)
      );

      logic [1:0]       psel_d  = '0;
      logic [1:0]       write_d = '0;
      logic [1:0][31:0] addr_d  = '0;
      logic [1:0][31:0] wdata_d = '0;
      logic [1:0][3:0]  strb_d  = '0;
      logic             s_rdy   = 1'b0;
      logic             s_err_d = 1'b0;
      logic [31:0]      s_rdata_d = '0;
      logic [1:0]       rdy_o, err_o;
      logic [1:0][31:0] rd_o;

      assign m0_bus.psel    = psel_d[0];
      assign m0_bus.penable = psel_d[0];
      assign m0_bus.paddr   = addr_d[0];
      assign m0_bus.pwrite  = write_d[0];
      assign m0_bus.pwdata  = wdata_d[0];
      assign m0_bus.pwstrb  = strb_d[0];
      assign m1_bus.psel    = psel_d[1];
      assign m1_bus.penable = psel_d[1];
      assign m1_bus.paddr   = addr_d[1];
      assign m1_bus.pwrite  = write_d[1];
      assign m1_bus.pwdata  = wdata_d[1];
      assign m1_bus.pwstrb  = strb_d[1];
      assign ds_bus.pready  = s_rdy;
      assign ds_bus.prdata  = s_rdata_d;
      assign ds_bus.pslverr = s_err_d;
      assign rdy_o = {m1_bus.pready, m0_bus.pready};
      assign err_o = {m1_bus.pslverr, m0_bus.pslverr};
      assign rd_o  = {m1_bus.prdata, m0_bus.prdata};

      // Model: each granted transfer is a schedule (setup cycle, response cycle) plus
      // the latched request and the slave's planned answer.
      int          cyc = 0, t_setup = -1, t_resp = -1, s_wait = 0, w = 0, n_xfer = 0;
      bit          lastg = 1'b1, tmo = 1'b0, e_psel, e_pen, s_err_m = 1'b0, g_write = 1'b0;
      logic [31:0] g_addr = '0, g_wdata = '0, s_data = '0;
      logic [3:0]  g_strb = '0;
      logic [1:0]  outst = '0;

      always @(negedge clk) begin
         if (!rst_n) begin
            cyc = 0; t_setup = -1; t_resp = -1; lastg = 1'b1; tmo = 1'b0;
            outst = '0; psel_d = '0; s_rdy = 1'b0;
            chk(tg(g, "rst psel"), 32'(ds_bus.psel), 32'd0);
            chk(tg(g, "rst penable"), 32'(ds_bus.penable), 32'd0);
            chk(tg(g, "rst pready"), 32'(rdy_o), 32'd0);
            chk(tg(g, "rst paddr"), ds_bus.paddr, 32'd0);
         end else begin
            cyc++;
            e_psel = (cyc >= t_setup) && (cyc < t_resp);
            e_pen  = (cyc >  t_setup) && (cyc < t_resp);
            chk(tg(g, "psel"), 32'(ds_bus.psel), 32'(e_psel));
            chk(tg(g, "penable"), 32'(ds_bus.penable), 32'(e_pen));
            for (int x = 0; x < 2; x++) begin
               chk(tg(g, $sformatf("m%0d_pready", x)), 32'(rdy_o[x]),
                   32'((cyc == t_resp) && (w == x)));
            end
            if (e_psel) begin
               chk(tg(g, "paddr"), ds_bus.paddr, g_addr);
               chk(tg(g, "pwrite"), 32'(ds_bus.pwrite), 32'(g_write));
               chk(tg(g, "pwdata"), ds_bus.pwdata, g_wdata);
               chk(tg(g, "pwstrb"), 32'(ds_bus.pwstrb), 32'(g_strb));
            end
            if (cyc == t_resp) begin
               chk(tg(g, "prdata"), rd_o[w], tmo ? 32'd0 : s_data);
               chk(tg(g, "pslverr"), 32'(err_o[w]), 32'(tmo ? 1'b1 : s_err_m));
            end

            // slave answer for the current cycle; stray pready outside ACCESS must be ignored
            if (e_pen && !tmo && (cyc == t_setup + 1 + s_wait)) begin
               s_rdy = 1'b1; s_rdata_d = s_data; s_err_d = s_err_m;
            end else begin
               s_rdy     = e_pen ? 1'b0 : ($urandom_range(3) == 0);
               s_rdata_d = $urandom;
               s_err_d   = 1'($urandom_range(1));
            end

            if (cyc == t_resp) begin
               outst[w] = 1'b0; psel_d[w] = 1'b0; n_xfer++;
            end

            for (int x = 0; x < 2; x++) begin
               if (!outst[x] && req_en[x] && ($urandom_range(99) < p_req)) begin
                  outst[x]   = 1'b1;
                  psel_d[x]  = 1'b1;
                  addr_d[x]  = $urandom;
                  wdata_d[x] = $urandom;
                  strb_d[x]  = 4'($urandom);
                  write_d[x] = 1'($urandom_range(1));
                  if (field_mode == 1) begin
                     addr_d[x] = 32'h1000_0000; wdata_d[x] = 32'hDEAD_BEEF;
                     strb_d[x] = 4'hF;          write_d[x] = 1'b1;
                  end else if (field_mode == 2) begin
                     write_d[x] = 1'b0;
                  end
               end
            end

            // granted master changes its fields or drops psel mid-transfer
            if (field_mode == 0 && e_psel) begin
               addr_d[w]  = $urandom;
               wdata_d[w] = $urandom;
               strb_d[w]  = 4'($urandom);
               write_d[w] = ~write_d[w];
               if ($urandom_range(7) == 0) psel_d[w] = 1'b0;
            end

            if ((cyc > t_resp) && (psel_d != 2'b00)) begin
               if (psel_d == 2'b11) w = (g == 1) ? 0 : int'(!lastg);
               else                 w = psel_d[1] ? 1 : 0;
               lastg   = 1'(w);
               g_addr  = addr_d[w];  g_wdata = wdata_d[w];
               g_strb  = strb_d[w];  g_write = write_d[w];
               if (force_wait >= 0) s_wait = force_wait;
               else begin
                  s_wait = $urandom_range(15);
                  if (s_wait < 8)       s_wait = s_wait % 4;
                  else if (s_wait < 12) s_wait = s_wait - 3;
                  else                  s_wait = 40;
               end
               tmo     = (s_wait >= TMO);
               t_setup = cyc + 1;
               t_resp  = cyc + 3 + (tmo ? TMO - 1 : s_wait);
               s_data  = $urandom;
               s_err_m = (field_mode == 1) ? 1'b0 : 1'($urandom_range(1));
            end
         end
      end
   end

   task automatic run_phase(input logic [1:0] en, input int preq, input int fw,
                            input int fm, input int nx, input string name);
      int base0, base1, n;
      bit done;
      @(posedge clk); #1;
      base0 = inst[0].n_xfer; base1 = inst[1].n_xfer;
      req_en = en; p_req = preq; force_wait = fw; field_mode = fm;
      n = 0;
      while (((inst[0].n_xfer - base0) < nx || (inst[1].n_xfer - base1) < nx) && n < 3000) begin
         @(posedge clk); n++;
      end
      #1 req_en = 2'b00;
      n = 0;
      while ((inst[0].outst != 2'b00 || inst[1].outst != 2'b00) && n < 200) begin
         @(posedge clk); n++;
      end
      done = ((inst[0].n_xfer - base0) >= nx) && ((inst[1].n_xfer - base1) >= nx)
             && (inst[0].outst == 2'b00) && (inst[1].outst == 2'b00);
      chk({name, " done"}, 32'(done), 32'd1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int  n;
      bit  seen;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      run_phase(2'b01, 100, 0, 1, 1, "single_write");
      run_phase(2'b11, 100, 0, 3, 4, "tie_hold");
      run_phase(2'b10, 100, 5, 2, 1, "m1_read_wait5");
      run_phase(2'b01, 100, 40, 2, 1, "timeout");

      // asynchronous reset in the middle of a long ACCESS phase
      @(posedge clk); #1;
      req_en = 2'b01; p_req = 100; force_wait = 6; field_mode = 3;
      n = 0; seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk); n++;
         seen = inst[0].ds_bus.psel && inst[0].ds_bus.penable;
      end
      chk("access_reached", 32'(seen), 32'd1);
      @(posedge clk); #2;
      req_en = 2'b00;
      rst_n  = 1'b0;
      #1;
      for (int i = 0; i < 1; i++) begin
         chk("async psel i0", 32'(inst[0].ds_bus.psel), 32'd0);
         chk("async penable i0", 32'(inst[0].ds_bus.penable), 32'd0);
         chk("async pready i0", 32'(inst[0].rdy_o), 32'd0);
         chk("async psel i1", 32'(inst[1].ds_bus.psel), 32'd0);
         chk("async penable i1", 32'(inst[1].ds_bus.penable), 32'd0);
         chk("async pready i1", 32'(inst[1].rdy_o), 32'd0);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      run_phase(2'b10, 100, -1, 3, 2, "m1_after_reset");
      run_phase(2'b11, 40, -1, 0, 60, "random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
